// File: rtl/proc_scan_pkg.sv
// Shared widths and FSM encoding for the register-file scan reader.
package proc_scan_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_idx_counter.sv
// Wrapping register-index counter: loads the scan bounds, steps modulo 2^ADDR_W,
// and flags when the current index equals the latched last index.
module scan_idx_counter #(
  parameter int unsigned ADDR_W = proc_scan_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_first,
  input  logic [ADDR_W-1:0] load_last,
  output logic [ADDR_W-1:0] idx,
  output logic              is_last_c
);

  logic [ADDR_W-1:0] idx_q  = '0;
  logic [ADDR_W-1:0] last_q = '0;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      idx_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      idx_q  <= load_first;
      last_q <= load_last;
    end else if (inc) begin
      idx_q  <= idx_q + ADDR_W'(1);
    end
  end

  assign idx       = idx_q;
  assign is_last_c = (idx_q == last_q);

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks a register file from first_reg to last_reg (wrapping), presenting one
// registered word per index on a valid/ready port; register 0 always reads zero.
module regfile_scan_reader #(
  parameter int unsigned DATA_W = proc_scan_pkg::DATA_W,
  parameter int unsigned ADDR_W = proc_scan_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  import proc_scan_pkg::*;

  scan_state_e       state_q     = IDLE;
  logic              out_valid_q = 1'b0;
  logic [DATA_W-1:0] out_data_q  = '0;
  logic [ADDR_W-1:0] out_idx_q   = '0;
  logic              busy_q      = 1'b0;
  logic              done_q      = 1'b0;

  logic [ADDR_W-1:0] idx;
  logic              is_last_c;
  logic              load_c;
  logic              inc_c;
  logic              accept_c;

  // Counter strobes share the FSM's priority order: reset, abort, then state.
  assign accept_c = (state_q == HOLD) && out_valid_q && out_ready;
  assign load_c   = clr_n && !abort && (state_q == IDLE) && start;
  assign inc_c    = clr_n && !abort && accept_c && !is_last_c;

  scan_idx_counter #(
    .ADDR_W(ADDR_W)
  ) u_idx (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (load_c),
    .inc       (inc_c),
    .load_first(first_reg),
    .load_last (last_reg),
    .idx       (idx),
    .is_last_c (is_last_c)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end
          end
          READ: begin
            // Register 0 is hardwired to zero whatever the file returns.
            out_data_q  <= (idx == '0) ? '0 : rd_data;
            out_idx_q   <= idx;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
          HOLD: begin
            if (accept_c) begin
              out_valid_q <= 1'b0;
              if (is_last_c) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                state_q <= READ;
              end
            end
          end
          default: begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  // The counter index is itself a register, so the read port is driven directly.
  assign rd_addr   = idx;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: scans push expected words, a negedge
// monitor pops and compares each accepted word, the done pulse and stall stability.
module tb_regfile_scan_reader;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;

  regfile_scan_reader dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .abort    (abort),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [0:31];
  assign rd_data = regs[rd_addr];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic mon_en   = 1'b0;
  logic done_exp = 1'b0;
  logic stalled_prev = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: done pulse, stall stability, and in-order word comparison.
  always @(negedge clk) begin
    if (mon_en) begin
      check("done_pulse", 32'(done), 32'(done_exp));
      if (done) done_cnt++;
      done_exp = 1'b0;
      if (stalled_prev && out_valid) begin
        check("stall_data", out_data, prev_data);
        check("stall_idx", 32'(out_idx), 32'(prev_idx));
      end
      if (clr_n && !abort && out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("word_idx", 32'(out_idx), 32'(e.idx));
          check("word_data", out_data, e.data);
          done_exp = e.last;
        end
      end
      stalled_prev = clr_n && !abort && out_valid && !out_ready;
      prev_data    = out_data;
      prev_idx     = out_idx;
    end
  end

  task automatic push_scan(input int f, input int l);
    exp_t e;
    for (int n = 0; n < 32; n++) begin
      int i;
      i      = (f + n) % 32;
      e.idx  = 5'(i);
      e.data = (i == 0) ? 32'h0 : regs[i];
      e.last = (i == l);
      q.push_back(e);
      if (i == l) break;
    end
  endtask

  task automatic do_start(input int f, input int l, input bit chk_lat);
    @(posedge clk); #1;
    start     = 1'b1;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    push_scan(f, l);
    @(posedge clk); #1;
    start     = 1'b0;
    first_reg = ~5'(f);
    last_reg  = ~5'(l);
    if (chk_lat) begin
      @(negedge clk);
      check("lat_read_valid", 32'(out_valid), 32'd0);
      check("lat_read_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("lat_first_valid", 32'(out_valid), 32'd1);
      check("lat_first_idx", 32'(out_idx), 32'(f));
    end
  endtask

  task automatic wait_idx_valid(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 5'(i)) && n < 200);
    check("wait_idx_valid", 32'(out_valid && out_idx == 5'(i)), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("scan_drained", 32'(q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hC000_0000 | (32'(i) << 8) | 32'(i);
    regs[0] = 32'hDEAD_BEEF;
    clr_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_reg = '0; last_reg = '0;

    #2;
    check("t0_valid", 32'(out_valid), 32'd0);
    check("t0_busy", 32'(busy), 32'd0);
    check("t0_done", 32'(done), 32'd0);
    check("t0_data", out_data, 32'd0);

    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    mon_en = 1'b1;

    // Scan 3..5, ready always high, with latency check.
    do_start(3, 5, 1'b1);
    wait_idle();

    // Wrap-around scan through the zero register.
    do_start(30, 1, 1'b0);
    wait_idle();

    // Stall idx 4 for five cycles, then a start pulse while busy.
    do_start(2, 6, 1'b0);
    wait_idx_valid(3);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_idx_valid(4);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // Abort while holding idx 7 of scan 5..10.
    do_start(5, 10, 1'b0);
    wait_idx_valid(6);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_idx_valid(7);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Single-word scan after abort.
    do_start(9, 9, 1'b0);
    wait_idle();

    // Reset mid-scan, with a start pulsed while busy just before.
    do_start(10, 20, 1'b0);
    wait_idx_valid(13);
    @(posedge clk); #1 start = 1'b1; first_reg = 5'd0; last_reg = 5'd0;
    @(posedge clk); #1 start = 1'b0; clr_n = 1'b0;
    @(posedge clk); #1 clr_n = 1'b1;
    q.delete();
    @(negedge clk);
    check("mrst_rd_addr", 32'(rd_addr), 32'd0);
    check("mrst_out_data", out_data, 32'd0);
    check("mrst_out_idx", 32'(out_idx), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("done_count", 32'(done_cnt), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
